// File: rtl/array_column_packer.sv
// rtl/array_column_packer.sv - serial element to packed-column word sequencer (optional flush: ARRAY_PACKER_FLUSH_EN)
module array_column_packer #(
  parameter  int BIT_WIDTH = 4,
  parameter  int COLS      = 8,
  localparam int CW        = $clog2(COLS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BIT_WIDTH-1:0]      in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [COLS*BIT_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef ARRAY_PACKER_FLUSH_EN
  input  logic                      flush,
`endif
  output logic [CW-1:0]             out_count
);

  localparam int IW = $clog2(COLS);

  // FILL collects columns, FULL presents the word; the state bit doubles as out_valid
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]                         state_q;
  logic [COLS-1:0][BIT_WIDTH-1:0]     buf_q;
  logic [IW-1:0]                      col_q;
  logic [CW-1:0]                      count_q;
  logic                               beat;
  logic                               take;
  logic                               last;
  logic                               flush_go;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = buf_q;
  assign out_count = count_q;

  // Ready depends only on the output side, never on in_valid
  assign in_ready = !rst && (!out_valid || out_ready);
  assign beat     = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign last     = (col_q == IW'(COLS - 1));

`ifdef ARRAY_PACKER_FLUSH_EN
  assign flush_go = (state_q == ST_FILL) && flush && ((col_q != '0) || beat);
`else
  assign flush_go = 1'b0;
`endif

  // Column fill, word hand-off and early flush of a partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
    end else if (take) begin
      // Word leaves; an overlapping beat starts the next word at column 0
      state_q <= ST_FILL;
      buf_q   <= '0;
      count_q <= '0;
      col_q   <= '0;
      if (beat) begin
        buf_q[0] <= in_data;
        col_q    <= IW'(1);
      end
    end else begin
      if (beat) begin
        buf_q[col_q] <= in_data;
      end
      if (beat && last) begin
        state_q <= ST_FULL;
        count_q <= CW'(COLS);
        col_q   <= '0;
      end else if (flush_go) begin
        state_q <= ST_FULL;
        count_q <= CW'(col_q) + CW'(beat);
        col_q   <= '0;
      end else if (beat) begin
        col_q <= col_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_array_column_packer.sv
// tb/tb_array_column_packer.sv - directed and scoreboard bench for array_column_packer
module tb_array_column_packer;

  localparam int BW = 4;
  localparam int NC = 8;
  localparam int NE = 1000;
  localparam int NW = NE / NC;

  logic          clk;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_count;
`ifdef ARRAY_PACKER_FLUSH_EN
  logic          flush;
`endif

  int n_cmp;
  int n_err;

  array_column_packer #(.BIT_WIDTH(BW), .COLS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ARRAY_PACKER_FLUSH_EN
    .flush     (flush),
`endif
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef ARRAY_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_cmp++; if (out_count !== 4'd0) begin n_err++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_fill();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin
      in_valid = 1'b1; in_data = BW'(i + 1);
      tick();
      if (i < NC - 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_early_valid beat %0d: got %b expected 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_out_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'h87654321) begin n_err++; $display("FAIL fill_out_data: got %h expected 87654321", out_data); end
    n_cmp++; if (out_count !== 4'd8) begin n_err++; $display("FAIL fill_out_count: got %0d expected 8", out_count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL drain_out_data: got %h expected 00000000", out_data); end
    n_cmp++; if (out_count !== 4'd0) begin n_err++; $display("FAIL drain_out_count: got %0d expected 0", out_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      in_valid = 1'b1; in_data = BW'(NC - i);
      tick();
    end
    for (int h = 0; h < 5; h++) begin
      in_valid = 1'b1; in_data = 4'h9;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready cycle %0d: got %b expected 0", h, in_ready); end
      tick();
      n_cmp++; if (out_data !== 32'h12345678) begin n_err++; $display("FAIL hold_out_data cycle %0d: got %h expected 12345678", h, out_data); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid cycle %0d: got %b expected 1", h, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL overlap_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h00000009) begin n_err++; $display("FAIL overlap_col0: got %h expected 00000009", out_data); end
    for (int i = 1; i < NC; i++) begin
      in_valid = 1'b1; in_data = BW'(i);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h76543219) begin n_err++; $display("FAIL second_word: got %h expected 76543219", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL second_word_valid: got %b expected 1", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    int words;
    int stalls;
    words = 0; stalls = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4 * NC; k++) begin
      in_valid = 1'b1; in_data = BW'(k);
      if (in_ready !== 1'b1) stalls++;
      tick();
      n_cmp++; if (out_valid !== ((k % NC) == NC - 1)) begin n_err++; $display("FAIL stream_valid beat %0d: got %b expected %b", k, out_valid, ((k % NC) == NC - 1)); end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (out_data !== (words[0] ? 32'hFEDCBA98 : 32'h76543210)) begin
          n_err++; $display("FAIL stream_word %0d: got %h expected %h", words, out_data, (words[0] ? 32'hFEDCBA98 : 32'h76543210));
        end
        words++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    n_cmp++; if (words !== 4) begin n_err++; $display("FAIL stream_words: got %0d expected 4", words); end
    tick();
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = BW'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    n_cmp++; if (out_data !== 32'h00000CBA) begin n_err++; $display("FAIL partial_before_reset: got %h expected 00000cba", out_data); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL async_reset_data: got %h expected 00000000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL async_reset_ready: got %b expected 0", in_ready); end
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < NC; i++) begin
      in_valid = 1'b1; in_data = BW'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h87654321) begin n_err++; $display("FAIL after_reset_word: got %h expected 87654321", out_data); end
    n_cmp++; if (out_count !== 4'd8) begin n_err++; $display("FAIL after_reset_count: got %0d expected 8", out_count); end
    tick();
  endtask

`ifdef ARRAY_PACKER_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = BW'(10 + i);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'h00000CBA) begin n_err++; $display("FAIL flush_data: got %h expected 00000cba", out_data); end
    n_cmp++; if (out_count !== 4'd3) begin n_err++; $display("FAIL flush_count: got %0d expected 3", out_count); end
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_data = 4'h6; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (out_data !== 32'h00000065) begin n_err++; $display("FAIL flush_beat_data: got %h expected 00000065", out_data); end
    n_cmp++; if (out_count !== 4'd2) begin n_err++; $display("FAIL flush_beat_count: got %0d expected 2", out_count); end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [BW-1:0] elems [NE];
    logic [31:0]   expw  [NW];
    logic [31:0]   w;
    logic [31:0]   prev_data;
    logic          prev_hold;
    int idx;
    int got;
    int cycles;
    for (int e = 0; e < NE; e++) elems[e] = BW'($urandom_range(0, 15));
    for (int j = 0; j < NW; j++) begin
      w = '0;
      for (int c = 0; c < NC; c++) w[c*BW +: BW] = elems[j*NC + c];
      expw[j] = w;
    end
    idx = 0; got = 0; cycles = 0; prev_hold = 1'b0; prev_data = '0;
    while (got < NW && cycles < 20000) begin
      in_valid  = (idx < NE) && ($urandom_range(0, 3) != 0);
      in_data   = (idx < NE) ? elems[idx] : '0;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_err++; $display("FAIL rand_hold cycle %0d: got %b/%h expected 1/%h", cycles, out_valid, out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== expw[got] || out_count !== 4'd8) begin n_err++; $display("FAIL rand_word %0d: got %h/%0d expected %h/8", got, out_data, out_count, expw[got]); end
        got++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) idx++;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== NW) begin n_err++; $display("FAIL rand_word_total: got %0d expected %0d", got, NW); end
    n_cmp++; if (idx !== NE) begin n_err++; $display("FAIL rand_beat_total: got %0d expected %0d", idx, NE); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic_fill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
`ifdef ARRAY_PACKER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
